// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache controller.
package cache_pkg;

  localparam int unsigned AddrWidthDef  = 32;
  localparam int unsigned TagWidthDef   = 19;
  localparam int unsigned WordWidthDef  = 8;
  localparam int unsigned StatsWidth    = 16;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLookup    = 3'd1,
    StWriteback = 3'd2,
    StFill      = 3'd3,
    StRespond   = 3'd4
  } state_e;

  // Index bits are whatever the tag leaves of the address.
  function automatic int unsigned index_size(input int unsigned addr_w, input int unsigned tag_w);
    return addr_w - tag_w;
  endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Saturating hit/miss counters for cache_ctrl (built only with CACHE_CTRL_STATS_EN).
module cache_ctrl_stats
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  hit_i,
  input  logic                  miss_i,
  output logic [StatsWidth-1:0] hit_count_o,
  output logic [StatsWidth-1:0] miss_count_o
);

  logic [StatsWidth-1:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_i && (hit_q != '1)) begin
      hit_d = hit_q + 1'b1;
    end
    if (miss_i && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer for a direct-mapped write-back cache: lookup, victim writeback, refill.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WORD_SIZE = AddrWidthDef,
  parameter int unsigned TAG_SIZE          = TagWidthDef,
  parameter int unsigned WORD_SIZE         = WordWidthDef
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]         cpu_wdata,
  output logic                         cpu_ready,
  output logic [WORD_SIZE-1:0]         cpu_rdata,
  output logic                         cpu_err,
  output logic [ADDRESS_WORD_SIZE-1:0] line_addr,
  output logic                         line_try_read,
  output logic                         line_try_write,
  output logic                         line_cache_write,
  output logic [WORD_SIZE-1:0]         line_wdata,
  input  logic                         line_hit,
  input  logic                         line_valid,
  input  logic                         line_dirty,
  input  logic [WORD_SIZE-1:0]         line_rdata,
  input  logic [TAG_SIZE-1:0]          line_victim_tag,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]         mem_wdata,
  input  logic [WORD_SIZE-1:0]         mem_rdata,
  input  logic                         mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [StatsWidth-1:0]        hit_count,
  output logic [StatsWidth-1:0]        miss_count
`endif
);

  localparam int unsigned INDEX_SIZE = index_size(ADDRESS_WORD_SIZE, TAG_SIZE);

  state_e                         state_q, state_d;
  logic [ADDRESS_WORD_SIZE-1:0]   addr_q, addr_d;
  logic                           we_q, we_d;
  logic [WORD_SIZE-1:0]           wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]           rdata_q, rdata_d;
  logic                           refill_q, refill_d;
  logic                           err_q, err_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      refill_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      refill_q <= refill_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    refill_d = refill_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          we_d     = cpu_we;
          wdata_d  = cpu_wdata;
          refill_d = 1'b0;
          err_d    = 1'b0;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        if (line_hit) begin
          if (!we_q) begin
            rdata_d = line_rdata;
          end
          state_d = StRespond;
        end else if (refill_q) begin
          // A refill that still misses means the line array is broken; give up.
          err_d   = 1'b1;
          state_d = StRespond;
        end else if (line_valid && line_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StFill;
        end
      end
      StWriteback: begin
        if (mem_ack) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (mem_ack) begin
          refill_d = 1'b1;
          state_d  = StLookup;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    line_addr        = addr_q;
    line_try_read    = 1'b0;
    line_try_write   = 1'b0;
    line_cache_write = 1'b0;
    line_wdata       = wdata_q;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    cpu_ready        = 1'b0;
    cpu_err          = 1'b0;
    unique case (state_q)
      StLookup: begin
        line_try_read  = !we_q;
        line_try_write = we_q;
      end
      StWriteback: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_victim_tag, addr_q[INDEX_SIZE-1:0]};
        mem_wdata = line_rdata;
      end
      StFill: begin
        mem_req          = 1'b1;
        mem_addr         = addr_q;
        line_wdata       = mem_rdata;
        line_cache_write = mem_ack;
      end
      StRespond: begin
        cpu_ready = 1'b1;
        cpu_err   = err_q;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = rdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic first_lookup;
  assign first_lookup = (state_q == StLookup) && !refill_q;

  cache_ctrl_stats u_stats (
    .clk          (clk),
    .rst_b        (rst_b),
    .hit_i        (first_lookup && line_hit),
    .miss_i       (first_lookup && !line_hit),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );
`endif

endmodule
